// File: rtl/geo_feeder.sv
// Ping-pong frame buffer that replays 7-word geofence frames (test point + 6 vertices)
// to a downstream evaluator, then waits for its result pulse or a timeout.
module geo_feeder #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] in_x,
    input  logic [9:0] in_y,
    output logic       gf_reset,
    output logic [9:0] X,
    output logic [9:0] Y,
    input  logic       gf_valid,
    output logic [7:0] frames_done,
    output logic       timeout_err
);
    localparam int unsigned COORD_W     = 10;
    localparam int unsigned WORD_W      = 2 * COORD_W;
    localparam int unsigned FRAME_WORDS = 7;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned FRAMES_W    = 8;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {HOLD, PLAY, WAIT, REARM} state_t;

    state_t             state, state_d;
    logic [WORD_W-1:0]  bank [2][FRAME_WORDS];
    logic [1:0]         full, full_d;
    logic               wr_bank;
    logic               rd_bank, rd_bank_d;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   play_idx, play_idx_d;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_d;
    logic               gf_reset_d;
    logic               accept;
    logic               frame_end;
    logic               release_c, done_c, abort_c;
    logic [WORD_W-1:0]  play_word;

    assign in_ready  = !full[wr_bank];
    assign accept    = in_valid && in_ready;
    assign frame_end = accept && (wr_idx == LAST_IDX);

    // Frame storage: data only, validity lives in the full flags.
    always_ff @(posedge clk) begin
        if (accept) begin
            bank[wr_bank][wr_idx] <= {in_x, in_y};
        end
    end

    // A bank freed by the read side and a bank completed by the write side never coincide.
    always_comb begin
        full_d = full;
        if (release_c) begin
            full_d[rd_bank] = 1'b0;
        end
        if (frame_end) begin
            full_d[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
            full    <= '0;
        end else begin
            full <= full_d;
            if (frame_end) begin
                wr_bank <= !wr_bank;
                wr_idx  <= '0;
            end else if (accept) begin
                wr_idx <= wr_idx + IDX_W'(1);
            end
        end
    end

    // Read-side sequencing.
    always_comb begin
        state_d    = state;
        play_idx_d = play_idx;
        wait_cnt_d = wait_cnt;
        rd_bank_d  = rd_bank;
        release_c  = 1'b0;
        done_c     = 1'b0;
        abort_c    = 1'b0;
        case (state)
            HOLD: begin
                if (full[rd_bank]) begin
                    state_d    = PLAY;
                    play_idx_d = '0;
                end
            end
            PLAY: begin
                if (play_idx == LAST_IDX) begin
                    state_d    = WAIT;
                    play_idx_d = '0;
                    wait_cnt_d = '0;
                end else begin
                    play_idx_d = play_idx + IDX_W'(1);
                end
            end
            WAIT: begin
                if (gf_valid) begin
                    done_c    = 1'b1;
                    release_c = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    abort_c   = 1'b1;
                    release_c = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt + CNT_W'(1);
                end
                if (release_c) begin
                    state_d   = REARM;
                    rd_bank_d = !rd_bank;
                end
            end
            REARM: begin
                play_idx_d = '0;
                state_d    = full[rd_bank] ? PLAY : HOLD;
            end
            default: state_d = HOLD;
        endcase
        gf_reset_d = (state_d == HOLD) || (state_d == REARM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HOLD;
            play_idx    <= '0;
            wait_cnt    <= '0;
            rd_bank     <= 1'b0;
            gf_reset    <= 1'b1;
            frames_done <= '0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_d;
            play_idx <= play_idx_d;
            wait_cnt <= wait_cnt_d;
            rd_bank  <= rd_bank_d;
            gf_reset <= gf_reset_d;
            if (done_c) begin
                frames_done <= frames_done + FRAMES_W'(1);
            end
            if (abort_c) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign play_word = bank[rd_bank][play_idx];
    assign {X, Y}    = (state == PLAY) ? play_word : '0;

endmodule

// File: tb/tb_geo_feeder.sv
// Bench for geo_feeder: vector table, directed multi-cycle sequences and a
// random run checked every cycle against a frame-queue reference model.
`timescale 1ns/1ps
module tb_geo_feeder;
    localparam int TO_SHORT = 8;
    localparam int M_IDLE = 0, M_PLAY = 1, M_WAIT = 2, M_REARM = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       gf_valid = 1'b0;
    logic [9:0] in_x = '0, in_y = '0;

    logic       in_ready, gf_reset, timeout_err;
    logic [9:0] X, Y;
    logic [7:0] frames_done;
    logic       l_in_ready, l_gf_reset, l_timeout_err;
    logic [9:0] l_x, l_y;
    logic [7:0] l_frames_done;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    geo_feeder #(.TIMEOUT_CYC(TO_SHORT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .gf_reset(gf_reset), .X(X), .Y(Y),
        .gf_valid(gf_valid), .frames_done(frames_done), .timeout_err(timeout_err)
    );

    geo_feeder #(.TIMEOUT_CYC(255)) dut_long (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_x(in_x), .in_y(in_y), .gf_reset(l_gf_reset), .X(l_x), .Y(l_y),
        .gf_valid(gf_valid), .frames_done(l_frames_done), .timeout_err(l_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: complete frames waiting or playing, plus the frame being collected.
    typedef logic [6:0][19:0] frame_t;
    frame_t      pend[$];
    logic [19:0] part[$];
    int          m_mode = M_IDLE;
    int          m_pos = 0;
    int          m_waited = 0;
    int          m_frames = 0;
    int          m_err = 0;

    function automatic void model_step();
        bit acc;
        frame_t f;
        acc = in_valid && (pend.size() < 2);
        case (m_mode)
            M_IDLE: begin
                if (pend.size() > 0) begin
                    m_mode = M_PLAY;
                    m_pos  = 0;
                end
            end
            M_PLAY: begin
                if (m_pos == 6) begin
                    m_mode   = M_WAIT;
                    m_waited = 0;
                end else begin
                    m_pos++;
                end
            end
            M_WAIT: begin
                m_waited++;
                if (gf_valid) begin
                    m_frames = (m_frames + 1) % 256;
                    void'(pend.pop_front());
                    m_mode = M_REARM;
                end else if (m_waited == TO_SHORT) begin
                    m_err = 1;
                    void'(pend.pop_front());
                    m_mode = M_REARM;
                end
            end
            default: begin
                m_pos  = 0;
                m_mode = (pend.size() > 0) ? M_PLAY : M_IDLE;
            end
        endcase
        if (acc) begin
            part.push_back({in_x, in_y});
            if (part.size() == 7) begin
                for (int i = 0; i < 7; i++) f[i] = part[i];
                pend.push_back(f);
                part.delete();
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend.delete();
            part.delete();
            m_mode = M_IDLE; m_pos = 0; m_waited = 0; m_frames = 0; m_err = 0;
        end else begin
            model_step();
        end
    end

    frame_t      mon_f;
    logic [19:0] mon_w;
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            mon_w = '0;
            if (m_mode == M_PLAY && pend.size() > 0) begin
                mon_f = pend[0];
                mon_w = mon_f[m_pos];
            end
            check("mdl_in_ready", int'(in_ready), int'(pend.size() < 2));
            check("mdl_gf_reset", int'(gf_reset), int'(m_mode == M_IDLE || m_mode == M_REARM));
            check("mdl_x", int'(X), int'(mon_w[19:10]));
            check("mdl_y", int'(Y), int'(mon_w[9:0]));
            check("mdl_frames_done", int'(frames_done), m_frames);
            check("mdl_timeout_err", int'(timeout_err), m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; gf_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_gf_reset", int'(gf_reset), 1);
        check("rst_xy", int'({X, Y}), 0);
        check("rst_frames", int'(frames_done), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rel_in_ready", int'(in_ready), 1);
        check("rel_in_ready_long", int'(l_in_ready), 1);
    endtask

    task automatic send_word(input logic [19:0] w);
        int n = 0;
        in_valid = 1'b1;
        {in_x, in_y} = w;
        while (!in_ready && n < 300) begin
            tick();
            n++;
        end
        check("send_bound", int'(n < 300), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_play();
        int n = 0;
        while (gf_reset && n < 200) begin
            tick();
            n++;
        end
        check("play_start", int'(gf_reset), 0);
    endtask

    typedef struct {
        logic        vin;
        logic [19:0] din;
        logic        gv;
        logic        exp_ready;
        logic        exp_gfr;
        logic [19:0] exp_xy;
        logic [7:0]  exp_frames;
    } vec_t;

    vec_t        tv[20];
    logic [19:0] fr[7];
    logic [19:0] rw[21];

    initial begin
        int n, w, first_drop, bursts, gaps;
        logic rdy, gfr, prev_gfr;

        fr[0] = {10'd100, 10'd100}; fr[1] = {10'd50, 10'd50};   fr[2] = {10'd150, 10'd50};
        fr[3] = {10'd200, 10'd100}; fr[4] = {10'd150, 10'd150}; fr[5] = {10'd50, 10'd150};
        fr[6] = {10'd0, 10'd100};

        for (int i = 0; i < 20; i++) begin
            tv[i].vin = 1'b0; tv[i].din = '0; tv[i].gv = 1'b0; tv[i].exp_ready = 1'b1;
            tv[i].exp_gfr = 1'b1; tv[i].exp_xy = '0; tv[i].exp_frames = 8'd0;
        end
        for (int i = 0; i < 7; i++) begin
            tv[i].vin = 1'b1;
            tv[i].din = fr[i];
            tv[8 + i].exp_gfr = 1'b0;
            tv[8 + i].exp_xy = fr[i];
        end
        for (int i = 15; i < 18; i++) tv[i].exp_gfr = 1'b0;
        tv[17].gv = 1'b1;
        tv[18].exp_frames = 8'd1;
        tv[19].exp_frames = 8'd1;

        do_reset();
        mon_en = 1'b1;

        // Single frame, cycle by cycle.
        for (int i = 0; i < 20; i++) begin
            in_valid = tv[i].vin;
            {in_x, in_y} = tv[i].din;
            gf_valid = tv[i].gv;
            #3;
            check($sformatf("vec%0d_ready", i), int'(in_ready), int'(tv[i].exp_ready));
            check($sformatf("vec%0d_gf_reset", i), int'(gf_reset), int'(tv[i].exp_gfr));
            check($sformatf("vec%0d_xy", i), int'({X, Y}), int'(tv[i].exp_xy));
            check($sformatf("vec%0d_frames", i), int'(frames_done), int'(tv[i].exp_frames));
            tick();
        end
        in_valid = 1'b0; gf_valid = 1'b0;

        // Long evaluator latency on the default-timeout instance.
        do_reset();
        for (int i = 0; i < 7; i++) send_word(fr[i]);
        check("long_hold_after_accept", int'(l_gf_reset), 1);
        tick();
        check("long_play_first_gfr", int'(l_gf_reset), 0);
        check("long_play0", int'({l_x, l_y}), int'(fr[0]));
        for (int i = 1; i < 7; i++) begin
            tick();
            check($sformatf("long_play%0d", i), int'({l_x, l_y}), int'(fr[i]));
        end
        tick();
        repeat (20) tick();
        check("long_still_waiting", int'(l_gf_reset), 0);
        check("long_no_timeout", int'(l_timeout_err), 0);
        gf_valid = 1'b1;
        tick();
        gf_valid = 1'b0;
        check("long_frames", int'(l_frames_done), 1);
        check("long_rearm_gfr", int'(l_gf_reset), 1);

        // Timeout with no evaluator response, then the next frame still plays.
        do_reset();
        for (int i = 0; i < 7; i++) send_word(fr[i]);
        wait_play();
        n = 0;
        while (!gf_reset && n < 100) begin
            n++;
            tick();
        end
        check("to_low_cycles", n, 15);
        check("to_err", int'(timeout_err), 1);
        check("to_frames", int'(frames_done), 0);
        for (int i = 0; i < 7; i++) send_word(fr[6 - i]);
        wait_play();
        check("to_next_frame", int'({X, Y}), int'(fr[6]));

        // Result pulse on the last permitted WAIT cycle counts as completion.
        do_reset();
        for (int i = 0; i < 7; i++) send_word(fr[i]);
        wait_play();
        repeat (14) tick();
        gf_valid = 1'b1;
        tick();
        gf_valid = 1'b0;
        check("tie_frames", int'(frames_done), 1);
        check("tie_err", int'(timeout_err), 0);
        check("tie_gfr", int'(gf_reset), 1);

        // Reset in the middle of PLAY while the second frame is being written.
        do_reset();
        for (int i = 0; i < 14; i++) rw[i] = 20'($urandom);
        w = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            {in_x, in_y} = rw[w];
            rdy = in_ready;
            tick();
            if (rdy) w++;
            if (w == 14) in_valid = 1'b0;
            if (m_mode == M_PLAY && m_pos == 3) break;
        end
        check("midplay_reached", int'(m_mode == M_PLAY && m_pos == 3), 1);
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midplay_rst_gfr", int'(gf_reset), 1);
        check("midplay_rst_x", int'(X), 0);
        check("midplay_rst_y", int'(Y), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midplay_rel_ready", int'(in_ready), 1);
        n = 0;
        repeat (30) begin
            if (!gf_reset) n++;
            tick();
        end
        check("midplay_no_replay", n, 0);

        // Three frames streamed back-to-back with immediate results.
        do_reset();
        for (int i = 0; i < 21; i++) rw[i] = 20'($urandom);
        gf_valid = 1'b1;
        w = 0; first_drop = -1; bursts = 0; gaps = 0; prev_gfr = 1'b1;
        for (int c = 0; c < 200 && frames_done != 8'd3; c++) begin
            in_valid = (w < 21);
            {in_x, in_y} = rw[(w < 21) ? w : 0];
            rdy = in_ready;
            gfr = gf_reset;
            if (!rdy && first_drop < 0 && w < 21) first_drop = w;
            if (prev_gfr && !gfr) bursts++;
            if (gfr && bursts >= 1 && bursts < 3) gaps++;
            prev_gfr = gfr;
            tick();
            if (rdy && w < 21) w++;
        end
        gf_valid = 1'b0;
        in_valid = 1'b0;
        check("b2b_first_drop", first_drop, 14);
        check("b2b_bursts", bursts, 3);
        check("b2b_rearm_gaps", gaps, 2);
        check("b2b_frames", int'(frames_done), 3);

        // Stalled input mid-frame keeps the frame parked and in order.
        do_reset();
        for (int i = 0; i < 7; i++) rw[i] = 20'($urandom);
        for (int i = 0; i < 4; i++) send_word(rw[i]);
        n = 0;
        repeat (10) begin
            if (!gf_reset) n++;
            tick();
        end
        check("stall_no_play", n, 0);
        for (int i = 4; i < 7; i++) send_word(rw[i]);
        wait_play();
        for (int i = 0; i < 7; i++) begin
            check($sformatf("stall_word%0d", i), int'({X, Y}), int'(rw[i]));
            tick();
        end

        // Random traffic against the model, with one reset in the middle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_x = 10'($urandom);
            in_y = 10'($urandom);
            gf_valid = ($urandom_range(0, 5) == 0);
            if (c == 1500) reset = 1'b1;
            if (c == 1502) reset = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        gf_valid = 1'b0;
        tick();

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
